conv1d_job_sequencer: RTL and testbench

// - Drives the conv1d CFU command port (cmd/inp0/inp1/ret) without CPU involvement.
// - Loads the layer configuration once, then runs one output point per job: bias, start x, start, poll, read result.
// - Sits between a job-descriptor source (DMA/CPU FIFO) and the conv1d compute block; returns quantised int32 results.

---
 rtl/conv1d_seq_pkg.sv | 58 +++++
 rtl/conv1d_job_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_conv1d_job_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv1d_seq_pkg.sv
// Shared definitions for the conv1d job sequencer: CFU command codes,
// sequencer states, the layer-configuration record and the CFG command table.
package conv1d_seq_pkg;

  localparam int INT32_W = 32;

  // conv1d CFU command codes
  localparam logic [6:0] CMD_SET_INPUT_OFFSET = 7'd3;
  localparam logic [6:0] CMD_SET_INPUT_DEPTH  = 7'd5;
  localparam logic [6:0] CMD_START            = 7'd6;
  localparam logic [6:0] CMD_GET_RESULT       = 7'd7;
  localparam logic [6:0] CMD_SET_START_X      = 7'd8;
  localparam logic [6:0] CMD_POLL             = 7'd9;
  localparam logic [6:0] CMD_SET_BIAS         = 7'd12;
  localparam logic [6:0] CMD_SET_OUT_MULT     = 7'd13;
  localparam logic [6:0] CMD_SET_OUT_SHIFT    = 7'd14;
  localparam logic [6:0] CMD_SET_ACT_MIN      = 7'd15;
  localparam logic [6:0] CMD_SET_ACT_MAX      = 7'd16;
  localparam logic [6:0] CMD_SET_OUT_OFFSET   = 7'd17;
  localparam logic [6:0] CMD_NOP              = 7'd19;

  // Layer configuration is pushed to conv1d as seven consecutive commands.
  localparam int CFG_STEPS = 7;
  localparam logic [0:CFG_STEPS-1][6:0] CFG_CMD_TABLE = {
    CMD_SET_INPUT_OFFSET, CMD_SET_INPUT_DEPTH, CMD_SET_OUT_MULT,
    CMD_SET_OUT_SHIFT,    CMD_SET_ACT_MIN,     CMD_SET_ACT_MAX,
    CMD_SET_OUT_OFFSET
  };

  typedef enum logic [3:0] {
    IDLE, CFG, JB, JX, ST, POLL, RD, RW, OUT
  } state_t;

  typedef struct packed {
    logic [INT32_W-1:0] input_offset;
    logic [INT32_W-1:0] input_depth;
    logic [INT32_W-1:0] out_mult;
    logic [INT32_W-1:0] out_shift;
    logic [INT32_W-1:0] act_min;
    logic [INT32_W-1:0] act_max;
    logic [INT32_W-1:0] out_offset;
  } cfg_t;

  // Operand that accompanies CFG_CMD_TABLE[step].
  function automatic logic [INT32_W-1:0] cfg_field(input cfg_t c, input logic [2:0] step);
    case (step)
      3'd0:    return c.input_offset;
      3'd1:    return c.input_depth;
      3'd2:    return c.out_mult;
      3'd3:    return c.out_shift;
      3'd4:    return c.act_min;
      3'd5:    return c.act_max;
      3'd6:    return c.out_offset;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/conv1d_job_sequencer.sv
// Drives the conv1d CFU command port on its own: loads the layer config once,
// then for each job sets bias and start column, starts, polls for done and
// returns the quantised result over a valid/ready handshake.
module conv1d_job_sequencer
  import conv1d_seq_pkg::*;
#(
  parameter int INT32_SIZE     = INT32_W,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_DEPTH      = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [INT32_SIZE-1:0] cfg_input_offset,
  input  logic [INT32_SIZE-1:0] cfg_input_depth,
  input  logic [INT32_SIZE-1:0] cfg_out_mult,
  input  logic [INT32_SIZE-1:0] cfg_out_shift,
  input  logic [INT32_SIZE-1:0] cfg_act_min,
  input  logic [INT32_SIZE-1:0] cfg_act_max,
  input  logic [INT32_SIZE-1:0] cfg_out_offset,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [INT32_SIZE-1:0] job_start_x,
  input  logic [INT32_SIZE-1:0] job_bias,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [INT32_SIZE-1:0] res_data,
  output logic                  busy,
  output logic                  cfg_err,
  output logic                  timeout_err,
  output logic                  conv_en,
  output logic [6:0]            conv_cmd,
  output logic [INT32_SIZE-1:0] conv_inp0,
  output logic [INT32_SIZE-1:0] conv_inp1,
  input  logic [INT32_SIZE-1:0] conv_ret
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t                state_q, state_d;
  logic [2:0]            step_q, step_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic                  cfg_loaded_q, cfg_loaded_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  conv_en_q;
  logic                  res_valid_q, res_valid_d;
  logic [INT32_SIZE-1:0] res_data_q, res_data_d;
  cfg_t                  cfg_q, cfg_d;
  logic [INT32_SIZE-1:0] bias_q, bias_d;
  logic [INT32_SIZE-1:0] start_x_q, start_x_d;

  logic                  cfg_accept, job_accept, depth_bad;
  logic [6:0]            conv_cmd_c;
  logic [INT32_SIZE-1:0] conv_inp1_c;

  // conv_en_q doubles as "out of reset": handshakes stay closed while rst_n is low.
  assign cfg_ready  = conv_en_q && (state_q == IDLE);
  assign job_ready  = cfg_ready && cfg_loaded_q && !cfg_valid;
  assign cfg_accept = cfg_ready && cfg_valid;
  assign job_accept = job_ready && job_valid;
  assign depth_bad  = (cfg_input_depth == '0) ||
                      (cfg_input_depth > INT32_SIZE'(MAX_DEPTH));

  // Next-state, command issue and status updates.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d       = state_q;
    step_d        = step_q;
    tmr_d         = tmr_q;
    cfg_loaded_d  = cfg_loaded_q;
    cfg_err_d     = cfg_err_q;
    timeout_err_d = timeout_err_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    cfg_d         = cfg_q;
    bias_d        = bias_q;
    start_x_d     = start_x_q;
    conv_cmd_c    = CMD_NOP;
    conv_inp1_c   = '0;

    case (state_q)
      IDLE: begin
        if (cfg_accept) begin
          cfg_d = '{input_offset: cfg_input_offset, input_depth: cfg_input_depth,
                    out_mult: cfg_out_mult, out_shift: cfg_out_shift,
                    act_min: cfg_act_min, act_max: cfg_act_max,
                    out_offset: cfg_out_offset};
          cfg_loaded_d = 1'b0;
          if (depth_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            step_d  = '0;
            state_d = CFG;
          end
        end else if (job_accept) begin
          bias_d    = job_bias;
          start_x_d = job_start_x;
          state_d   = JB;
        end
      end
      CFG: begin
        conv_cmd_c  = CFG_CMD_TABLE[step_q];
        conv_inp1_c = cfg_field(cfg_q, step_q);
        if (step_q == 3'(CFG_STEPS - 1)) begin
          cfg_loaded_d = 1'b1;
          state_d      = IDLE;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      JB: begin
        conv_cmd_c  = CMD_SET_BIAS;
        conv_inp1_c = bias_q;
        state_d     = JX;
      end
      JX: begin
        conv_cmd_c  = CMD_SET_START_X;
        conv_inp1_c = start_x_q;
        state_d     = ST;
      end
      ST: begin
        conv_cmd_c = CMD_START;
        tmr_d      = '0;
        state_d    = POLL;
      end
      POLL: begin
        conv_cmd_c = CMD_POLL;
        tmr_d      = tmr_q + TMR_W'(1);
        // The first POLL cycle still sees the ret of the start command.
        if ((tmr_q != '0) && conv_ret[0]) begin
          state_d = RD;
        end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end
      RD: begin
        conv_cmd_c = CMD_GET_RESULT;
        state_d    = RW;
      end
      RW: begin
        res_data_d  = conv_ret;
        res_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q       <= IDLE;
      step_q        <= '0;
      tmr_q         <= '0;
      cfg_loaded_q  <= 1'b0;
      cfg_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      conv_en_q     <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      tmr_q         <= tmr_d;
      cfg_loaded_q  <= cfg_loaded_d;
      cfg_err_q     <= cfg_err_d;
      timeout_err_q <= timeout_err_d;
      conv_en_q     <= 1'b1;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
    end
  end

  // Captured operands; only read in states entered after a capture.
  always_ff @(posedge clk) begin
    // NOTE: pure data holding registers are not reset; control state guards their use.
    cfg_q     <= cfg_d;
    bias_q    <= bias_d;
    start_x_q <= start_x_d;
  end

  assign busy        = (state_q != IDLE);
  assign cfg_err     = cfg_err_q;
  assign timeout_err = timeout_err_q;
  assign conv_en     = conv_en_q;
  assign conv_cmd    = conv_cmd_c;
  assign conv_inp0   = '0;
  assign conv_inp1   = conv_inp1_c;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;

endmodule

// File: tb/tb_conv1d_job_sequencer.sv
// Directed bench for conv1d_job_sequencer with a mock conv1d (registered ret,
// scripted done/result).
module tb_conv1d_job_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid, cfg_ready;
  logic [31:0] cfg_input_offset, cfg_input_depth, cfg_out_mult, cfg_out_shift;
  logic [31:0] cfg_act_min, cfg_act_max, cfg_out_offset;
  logic        job_valid, job_ready;
  logic [31:0] job_start_x, job_bias;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        busy, cfg_err, timeout_err, conv_en;
  logic [6:0]  conv_cmd;
  logic [31:0] conv_inp0, conv_inp1, conv_ret;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    logic [6:0]  cmd;
    logic [31:0] inp1;
  } ent_t;
  ent_t log_q[$];
  logic res_seen;

  // Mock conv1d controls
  logic never_done;
  int   poll_cnt;

  conv1d_job_sequencer #(
    .INT32_SIZE(32), .TIMEOUT_CYCLES(16), .MAX_DEPTH(128)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_input_offset(cfg_input_offset), .cfg_input_depth(cfg_input_depth),
    .cfg_out_mult(cfg_out_mult), .cfg_out_shift(cfg_out_shift),
    .cfg_act_min(cfg_act_min), .cfg_act_max(cfg_act_max),
    .cfg_out_offset(cfg_out_offset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_start_x(job_start_x), .job_bias(job_bias),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .cfg_err(cfg_err), .timeout_err(timeout_err),
    .conv_en(conv_en), .conv_cmd(conv_cmd),
    .conv_inp0(conv_inp0), .conv_inp1(conv_inp1), .conv_ret(conv_ret)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Mock conv1d: ret answers the command of the previous cycle.
  // Non-poll commands return all ones so a stale ret looks like "done".
  always @(posedge clk) begin
    if (conv_cmd == 7'd9) begin
      conv_ret <= (!never_done && poll_cnt >= 6) ? 32'd1 : 32'd0;
      poll_cnt <= poll_cnt + 1;
    end else if (conv_cmd == 7'd6) begin
      conv_ret <= 32'hFFFF_FFFF;
      poll_cnt <= 0;
    end else if (conv_cmd == 7'd7) begin
      conv_ret <= 32'h0000_007F;
    end else begin
      conv_ret <= 32'hFFFF_FFFF;
    end
  end

  // Command and result monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && conv_cmd !== 7'd19) log_q.push_back('{cyc, conv_cmd, conv_inp1});
    if (res_valid === 1'b1) res_seen = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [31:0] depth);
    cfg_input_offset = 32'd128;
    cfg_input_depth  = depth;
    cfg_out_mult     = 32'h4000_0000;
    cfg_out_shift    = 32'hFFFF_FFFE;
    cfg_act_min      = 32'hFFFF_FF80;
    cfg_act_max      = 32'h0000_007F;
    cfg_out_offset   = 32'hFFFF_FFFB;
    cfg_valid        = 1'b1;
    log_q.delete();
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic start_job(input logic nd);
    never_done  = nd;
    job_start_x = 32'd3;
    job_bias    = 32'h100;
    job_valid   = 1'b1;
    log_q.delete();
    res_seen    = 1'b0;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_valid = 0; job_valid = 0; res_ready = 0; never_done = 0;
    cfg_input_offset = 0; cfg_input_depth = 0; cfg_out_mult = 0; cfg_out_shift = 0;
    cfg_act_min = 0; cfg_act_max = 0; cfg_out_offset = 0; job_start_x = 0; job_bias = 0;
    repeat (3) tick();
    n_cmp++; if (conv_cmd !== 7'd19) begin n_bad++; $display("FAIL reset_cmd: got %0d want 19", conv_cmd); end
    n_cmp++; if ({conv_en, busy, cfg_ready, job_ready, res_valid, cfg_err, timeout_err} !== 7'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000000", {conv_en, busy, cfg_ready, job_ready, res_valid, cfg_err, timeout_err}); end
    n_cmp++; if ({conv_inp0, conv_inp1, res_data} !== 96'b0) begin
      n_bad++; $display("FAIL reset_data: got %h %h %h want 0", conv_inp0, conv_inp1, res_data); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if ({conv_en, cfg_ready, job_ready, busy} !== 4'b1100) begin
      n_bad++; $display("FAIL post_reset: got en/cfg_rdy/job_rdy/busy=%b want 1100", {conv_en, cfg_ready, job_ready, busy}); end
  endtask

  task automatic test_config();
    logic [6:0]  exp_cmd [7];
    logic [31:0] exp_inp [7];
    exp_cmd = '{7'd3, 7'd5, 7'd13, 7'd14, 7'd15, 7'd16, 7'd17};
    exp_inp = '{32'd128, 32'd16, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FF80, 32'h7F, 32'hFFFF_FFFB};
    send_cfg(32'd16);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL cfg_busy: got %b want 1", busy); end
    repeat (8) tick();
    n_cmp++; if (log_q.size() != 7) begin n_bad++; $display("FAIL cfg_count: got %0d want 7", log_q.size()); end
    for (int i = 0; i < 7 && i < log_q.size(); i++) begin
      n_cmp++;
      if (log_q[i].cmd !== exp_cmd[i] || log_q[i].inp1 !== exp_inp[i] || log_q[i].cyc != log_q[0].cyc + i) begin
        n_bad++; $display("FAIL cfg_cmd%0d: got cmd %0d inp1 %h cyc+%0d want cmd %0d inp1 %h cyc+%0d",
                          i, log_q[i].cmd, log_q[i].inp1, log_q[i].cyc - log_q[0].cyc, exp_cmd[i], exp_inp[i], i);
      end
    end
    n_cmp++; if ({job_ready, busy, cfg_err} !== 3'b100) begin
      n_bad++; $display("FAIL cfg_done: got job_rdy/busy/cfg_err=%b want 100", {job_ready, busy, cfg_err}); end
  endtask

  task automatic test_job();
    int acc_cyc, n;
    n_cmp++; if (job_ready !== 1'b1) begin n_bad++; $display("FAIL job_ready: got %b want 1", job_ready); end
    acc_cyc = cyc;
    start_job(1'b0);
    n = 0;
    while (res_valid !== 1'b1 && n < 40) begin tick(); n++; end
    n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL job_res_valid: got %b want 1 within 40 cycles", res_valid); end
    n_cmp++; if (res_data !== 32'h7F) begin n_bad++; $display("FAIL job_res_data: got %h want 0000007f", res_data); end
    n_cmp++; if (log_q.size() != 12) begin n_bad++; $display("FAIL job_cmd_count: got %0d want 12", log_q.size()); end
    if (log_q.size() == 12) begin
      n_cmp++; if (log_q[0].cmd !== 7'd12 || log_q[0].inp1 !== 32'h100) begin
        n_bad++; $display("FAIL job_bias_cmd: got %0d/%h want 12/00000100", log_q[0].cmd, log_q[0].inp1); end
      n_cmp++; if (log_q[1].cmd !== 7'd8 || log_q[1].inp1 !== 32'd3) begin
        n_bad++; $display("FAIL job_startx_cmd: got %0d/%h want 8/00000003", log_q[1].cmd, log_q[1].inp1); end
      n_cmp++; if (log_q[2].cmd !== 7'd6) begin n_bad++; $display("FAIL job_start_cmd: got %0d want 6", log_q[2].cmd); end
      n_cmp++; if (log_q[3].cyc - acc_cyc != 4) begin
        n_bad++; $display("FAIL job_poll_latency: got %0d want 4", log_q[3].cyc - acc_cyc); end
      for (int i = 3; i < 11; i++) begin
        n_cmp++; if (log_q[i].cmd !== 7'd9) begin n_bad++; $display("FAIL job_poll%0d: got %0d want 9", i, log_q[i].cmd); end
      end
      n_cmp++; if (log_q[11].cmd !== 7'd7) begin n_bad++; $display("FAIL job_read_cmd: got %0d want 7", log_q[11].cmd); end
    end
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if ({res_valid, job_ready} !== 2'b10 || res_data !== 32'h7F) begin
        n_bad++; $display("FAIL bp_hold%0d: got valid/job_rdy=%b data %h want 10 0000007f", i, {res_valid, job_ready}, res_data); end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_cmp++; if ({res_valid, busy, job_ready} !== 3'b001) begin
      n_bad++; $display("FAIL bp_release: got valid/busy/job_rdy=%b want 001", {res_valid, busy, job_ready}); end
  endtask

  task automatic test_priority();
    cfg_input_depth = 32'd128;
    cfg_valid = 1'b1;
    job_valid = 1'b1;
    log_q.delete();
    #1;
    n_cmp++; if ({cfg_ready, job_ready} !== 2'b10) begin
      n_bad++; $display("FAIL prio_ready: got cfg_rdy/job_rdy=%b want 10", {cfg_ready, job_ready}); end
    tick();
    cfg_valid = 1'b0;
    job_valid = 1'b0;
    repeat (8) tick();
    n_cmp++; if (log_q.size() != 7) begin n_bad++; $display("FAIL prio_count: got %0d want 7", log_q.size()); end
    if (log_q.size() == 7) begin
      n_cmp++; if (log_q[0].cmd !== 7'd3 || log_q[1].inp1 !== 32'd128) begin
        n_bad++; $display("FAIL prio_cfg_first: got %0d depth %0d want 3 depth 128", log_q[0].cmd, log_q[1].inp1); end
    end
    n_cmp++; if ({cfg_err, job_ready} !== 2'b01) begin
      n_bad++; $display("FAIL prio_depth128: got cfg_err/job_rdy=%b want 01", {cfg_err, job_ready}); end
  endtask

  task automatic test_timeout();
    int n, polls;
    start_job(1'b1);
    n = 0;
    while (busy === 1'b1 && n < 40) begin tick(); n++; end
    polls = 0;
    foreach (log_q[i]) if (log_q[i].cmd == 7'd9) polls++;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL to_abort: got busy %b want 0 within 40 cycles", busy); end
    n_cmp++; if (polls != 16) begin n_bad++; $display("FAIL to_polls: got %0d want 16", polls); end
    n_cmp++; if ({timeout_err, res_seen, job_ready, cfg_err} !== 4'b1010) begin
      n_bad++; $display("FAIL to_flags: got to_err/res_seen/job_rdy/cfg_err=%b want 1010", {timeout_err, res_seen, job_ready, cfg_err}); end
  endtask

  task automatic test_cfg_err(input logic [31:0] depth, input logic exp_to);
    send_cfg(depth);
    repeat (8) tick();
    n_cmp++; if (log_q.size() != 0) begin n_bad++; $display("FAIL cfgerr_cmds depth %0d: got %0d want 0", depth, log_q.size()); end
    n_cmp++; if ({cfg_err, timeout_err, busy, job_ready} !== {1'b1, exp_to, 2'b00}) begin
      n_bad++; $display("FAIL cfgerr_flags depth %0d: got cfg_err/to_err/busy/job_rdy=%b want %b",
                        depth, {cfg_err, timeout_err, busy, job_ready}, {1'b1, exp_to, 2'b00}); end
  endtask

  task automatic test_reset_mid_poll();
    send_cfg(32'd16);
    repeat (8) tick();
    start_job(1'b1);
    repeat (5) tick();
    n_cmp++; if ({busy, conv_cmd} !== {1'b1, 7'd9}) begin
      n_bad++; $display("FAIL midpoll_state: got busy %b cmd %0d want 1 9", busy, conv_cmd); end
    rst_n = 1'b0;
    tick();
    n_cmp++; if ({busy, conv_en, cfg_ready, timeout_err, cfg_err} !== 5'b0 || conv_cmd !== 7'd19) begin
      n_bad++; $display("FAIL midpoll_reset: got busy/en/cfg_rdy/to/cfg_err=%b cmd %0d want 00000 19",
                        {busy, conv_en, cfg_ready, timeout_err, cfg_err}, conv_cmd); end
    rst_n = 1'b1;
    tick();
    job_valid = 1'b1;
    #1;
    n_cmp++; if ({cfg_ready, job_ready} !== 2'b10) begin
      n_bad++; $display("FAIL midpoll_release: got cfg_rdy/job_rdy=%b want 10", {cfg_ready, job_ready}); end
    repeat (3) tick();
    job_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midpoll_no_job: got busy %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    send_cfg(32'd16);
    repeat (8) tick();
    n_cmp++; if ({cfg_err, job_ready} !== 2'b11) begin
      n_bad++; $display("FAIL b2b_cfg: got cfg_err/job_rdy=%b want 11", {cfg_err, job_ready}); end
    test_job();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_cmp++; if ({res_valid, job_ready} !== 2'b01) begin
      n_bad++; $display("FAIL b2b_done: got valid/job_rdy=%b want 01", {res_valid, job_ready}); end
  endtask

  initial begin
    test_reset();
    test_config();
    test_job();
    test_backpressure();
    test_priority();
    test_timeout();
    test_cfg_err(32'd0, 1'b1);
    test_reset_mid_poll();
    test_cfg_err(32'd129, 1'b0);
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
